// File: rtl/sine_voice_mixer.sv
// sine_voice_mixer: snapshots the voice bank on a tick and mixes all gated voices through one shared sine ROM
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   sample_tick_in          one-cycle request to compute a sample
//   gate_in, phase_value_in per-voice active flags and phase words (captured on an accepted tick)
//   sample_out              signed mixed sample, held between updates
//   sample_valid_out        one-cycle pulse when sample_out updates
//   busy_out                high while a sample is in flight
//   overrun_count_out       saturating count of ticks dropped while busy
// Build option: define MIX_SATURATE_EN to clamp the scaled sum to the sample range instead of wrapping.
module sine_voice_mixer #(
   parameter int NUM_VOICES = 24,
   parameter int PHASE_W    = 32,
   parameter int ROM_ADDR_W = 8,
   parameter int SAMPLE_W   = 16,
   parameter int OUT_SHIFT  = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       sample_tick_in,
   input  logic [NUM_VOICES-1:0]      gate_in,
   input  logic [PHASE_W-1:0]         phase_value_in [NUM_VOICES],
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid_out,
   output logic                       busy_out,
   output logic [7:0]                 overrun_count_out
);
   localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int ROM_N = 2 ** ROM_ADDR_W;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;
   function automatic logic [SAMPLE_W-1:0] sine_entry(input int k);
      real x;
      x = real'(2 ** (SAMPLE_W - 1) - 1) * $sin(2.0 * 3.14159265358979 * real'(k) / real'(ROM_N));
      return SAMPLE_W'($rtoi(x < 0.0 ? x - 0.5 : x + 0.5));
   endfunction
   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [ROM_ADDR_W-1:0]        snap_addr_q [NUM_VOICES];
   logic [NUM_VOICES-1:0]        snap_gate_q;
   logic [ROM_ADDR_W-1:0]        addr_q;
   logic signed [SAMPLE_W-1:0]   data_q;
   logic                         gate_d1_q, gate_d2_q;
   logic signed [ACC_W-1:0]      acc_q;
   logic signed [SAMPLE_W-1:0]   sample_q, sample_d;
   logic                         valid_q;
   logic [7:0]                   overrun_q;
   logic [SAMPLE_W-1:0]          rom [ROM_N];
   logic [NUM_VOICES-1:0]        phase_unused;
   for (genvar k = 0; k < ROM_N; k++) begin : g_rom
      assign rom[k] = sine_entry(k);
   end
   // only the top ROM_ADDR_W phase bits address the table
   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_unused
      assign phase_unused[v] = ^phase_value_in[v][PHASE_W-ROM_ADDR_W-1:0];
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            state_d = sample_tick_in ? ISSUE : IDLE;
            idx_d   = '0;
         end
         ISSUE: begin
            state_d = idx_q == IDX_W'(NUM_VOICES - 1) ? DRAIN : ISSUE;
            idx_d   = idx_q == IDX_W'(NUM_VOICES - 1) ? '0 : idx_q + 1'b1;
         end
         // two cycles let the last voice's data clear the ROM pipeline
         DRAIN: begin
            state_d = idx_q == IDX_W'(1) ? OUTPUT : DRAIN;
            idx_d   = idx_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
`ifdef MIX_SATURATE_EN
   localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(2 ** (SAMPLE_W - 1)));
   logic signed [ACC_W-1:0] scaled;
   assign scaled   = acc_q >>> OUT_SHIFT;
   assign sample_d = scaled > S_MAX ? SAMPLE_W'(S_MAX) : scaled < S_MIN ? SAMPLE_W'(S_MIN) : SAMPLE_W'(scaled);
`else
   assign sample_d = SAMPLE_W'(acc_q >>> OUT_SHIFT);
`endif
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         snap_gate_q <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         gate_d1_q   <= 1'b0;
         gate_d2_q   <= 1'b0;
         acc_q       <= '0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= '0;
         for (int v = 0; v < NUM_VOICES; v++) snap_addr_q[v] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= snap_addr_q[idx_q];
         data_q    <= rom[addr_q];
         // gate travels alongside the address so it lines up with the ROM data
         gate_d1_q <= state_q == ISSUE && snap_gate_q[idx_q];
         gate_d2_q <= gate_d1_q;
         valid_q   <= state_q == OUTPUT;
         if (state_q == IDLE && sample_tick_in) begin
            snap_gate_q <= gate_in;
            acc_q       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) snap_addr_q[v] <= phase_value_in[v][PHASE_W-1 -: ROM_ADDR_W];
         end else if (gate_d2_q) begin
            acc_q <= acc_q + ACC_W'(data_q);
         end
         if (state_q == OUTPUT) sample_q <= sample_d;
         if (sample_tick_in && state_q != IDLE && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
      end
   end
   assign sample_out        = sample_q;
   assign sample_valid_out  = valid_q;
   assign busy_out          = state_q != IDLE;
   assign overrun_count_out = overrun_q;
endmodule

// File: doc/sine_voice_mixer.md
Name: sine_voice_mixer

Overview:
- Stage directly downstream of the per-voice phase accumulator bank.
- On each sample tick, snapshots all 24 voice phases and gates, then walks the voices one per cycle through an internal sine ROM with 2-cycle read latency.
- Sums the gated voices, scales and clamps the sum, and emits one signed mono sample with a valid pulse to the audio output path (PDM/PWM).
- Time-multiplexes a single ROM port, so one BRAM serves all voices.

Parameters:
- NUM_VOICES, 24, voice count; must match the phase accumulator bank.
- PHASE_W, 32, width of each phase word.
- ROM_ADDR_W, 8, sine table depth is 2^ROM_ADDR_W; address = phase[PHASE_W-1 -: ROM_ADDR_W].
- SAMPLE_W, 16, signed width of ROM entries and of sample_out.
- OUT_SHIFT, 2, arithmetic right shift applied to the accumulated sum.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- sample_tick_in  input  1  one-cycle request to compute a sample.
- gate_in  input  NUM_VOICES  per-voice active flags.
- phase_value_in  input  PHASE_W x [NUM_VOICES]  unpacked array of voice phases.
- sample_out  output  SAMPLE_W  signed mixed sample, held until the next update.
- sample_valid_out  output  1  one-cycle pulse when sample_out updates.
- busy_out  output  1  high while a sample is in flight.
- overrun_count_out  output  8  saturating count of ticks dropped while busy.

Behaviour:
- Reset (rst_in high at a clock edge):
  - sample_out=0, sample_valid_out=0, busy_out=0, overrun_count_out=0.
  - Accumulator and voice index cleared; state goes to IDLE.
  - Reset mid-operation aborts the sample; no valid pulse follows.
- ROM: entry k = round(32767*sin(2*pi*k/256)), signed 16-bit, e.g. [0]=0, [32]=23170, [64]=32767, [192]=-32767. Registered address plus registered data gives 2-cycle latency.
- Accumulator width: ACC_W = SAMPLE_W + ceil(log2(NUM_VOICES)) = 21, signed. No overflow is possible at defaults.
- FSM: IDLE -> ISSUE -> DRAIN -> OUTPUT -> IDLE. Cycle 0 is the cycle where sample_tick_in is seen high in IDLE.
  - IDLE: on tick, register gate_in and phase_value_in into a snapshot, clear the accumulator, set busy_out.
  - ISSUE, cycles 1..24: present the ROM address for voice i = cycle-1.
  - Accumulate stage, cycles 3..26: add ROM data for voice i if snapshot gate[i]=1, else add 0. Gating is applied to the snapshot, not to live gate_in.
  - DRAIN, cycles 25..26.
  - OUTPUT, cycle 27: compute scaled = acc >>> OUT_SHIFT, convert to SAMPLE_W (see Optional Feature), register the result.
  - Cycle 28: sample_out updated, sample_valid_out=1 for exactly one cycle, busy_out=0, state IDLE.
- Latency: valid pulse exactly 28 cycles after the accepted tick. A tick in cycle 28 is accepted, so the minimum sustained tick period is 28 cycles.
- Overrun: a tick arriving while busy_out=1 is ignored and increments overrun_count_out, saturating at 255. It does not restart or alter the in-flight sample.
- Input changes after cycle 0 have no effect on the in-flight sample.
- sample_out holds its value between valid pulses.

Optional Feature:
- Macro MIX_SATURATE_EN.
- Defined: scaled values above 32767 clamp to 32767; values below -32768 clamp to -32768.
- Undefined: sample_out = low SAMPLE_W bits of the scaled value (two's-complement wrap). Saves the comparator logic.

Test Plan:
1. Assert rst_in 2 cycles -> all outputs 0, busy_out=0. Tick with gate_in=0 -> sample_out=0, valid at cycle 28.
2. gate_in[5]=1 only, phase_value_in[5]=0x4000_0000, tick -> sum 32767, sample_out=8191 (0x1FFF), valid at exactly cycle 28, busy_out high on cycles 1..27.
3. All 24 gates on, all phases 0x4000_0000, tick -> sum 786408, scaled 196602:
   - MIX_SATURATE_EN defined -> sample_out=32767.
   - MIX_SATURATE_EN undefined -> sample_out=0xFFFA (-6).
4. gate[0]=gate[1]=1, phase[0]=0x4000_0000, phase[1]=0xC000_0000 -> sample_out=0. Then gate[2]=0 with phase[2]=0x4000_0000 -> still 0 (ungated voice ignored).
5. Tick at cycle 0. Change phase[5] at cycle 2 and tick again at cycle 10 -> output reflects the cycle-0 snapshot, overrun_count_out=1. Tick at cycle 28 -> accepted, second valid at cycle 56.
6. Tick, then rst_in at cycle 12 -> no valid pulse, sample_out=0, busy_out=0, overrun_count_out=0. Next tick completes normally.
